// File: rtl/fan_pwm_ctrl.sv
// Fan driver sequencing controller.
// Turns a run request plus a duty setting into one registered enable for the fan driver.
// A start goes through a full-on kick-start, then PWM at the latched duty.
// Every stop goes through a minimum-off lockout before the fan may restart.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   i_req    - fan run request (level)
//   i_duty   - requested on-fraction, i_duty / 2^PWM_W; all-ones means 100 %
//   i_force  - emergency full speed (level); acts as a request and overrides duty in RUN
//   o_fan_en - registered enable to the fan driver
//   o_state  - current state: 00 IDLE, 01 KICK, 10 RUN, 11 LOCKOUT
//   o_busy   - high whenever the state is not IDLE
module fan_pwm_ctrl #(
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned PRESC       = 4,
  parameter int unsigned KICK_CYC    = 1024,
  parameter int unsigned MIN_OFF_CYC = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [PWM_W-1:0] i_duty,
  input  logic             i_force,
  output logic             o_fan_en,
  output logic [1:0]       o_state,
  output logic             o_busy
);

  localparam int unsigned CycMax = (KICK_CYC > MIN_OFF_CYC) ? KICK_CYC : MIN_OFF_CYC;
  // Counts 0..CycMax-1 only, so it never wraps inside a state.
  localparam int unsigned CycW   = (CycMax > 1) ? $clog2(CycMax) : 1;
  localparam int unsigned PrescW = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [CycW-1:0]   KickLast  = CycW'(KICK_CYC - 1);
  localparam logic [CycW-1:0]   OffLast   = CycW'(MIN_OFF_CYC - 1);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESC - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StKick    = 2'b01,
    StRun     = 2'b10,
    StLockout = 2'b11
  } state_e;

  state_e             r_state,     w_state_d;
  logic [CycW-1:0]    r_cyc_cnt,   w_cyc_cnt_d;
  logic [PrescW-1:0]  r_presc_cnt, w_presc_cnt_d;
  logic [PWM_W-1:0]   r_pwm_cnt,   w_pwm_cnt_d;
  logic [PWM_W-1:0]   r_duty_q,    w_duty_q_d;
  logic               r_fan_en,    w_fan_en_d;
  logic               w_run;

  assign w_run = i_req | i_force;

  always_comb begin
    w_state_d     = r_state;
    w_cyc_cnt_d   = r_cyc_cnt;
    w_presc_cnt_d = r_presc_cnt;
    w_pwm_cnt_d   = r_pwm_cnt;
    w_duty_q_d    = r_duty_q;
    w_fan_en_d    = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_run) begin
          w_state_d   = StKick;
          w_cyc_cnt_d = '0;
        end
      end
      StKick: begin
        if (!w_run) begin
          w_state_d   = StLockout;
          w_cyc_cnt_d = '0;
        end else if (r_cyc_cnt == KickLast) begin
          w_state_d     = StRun;
          w_presc_cnt_d = '0;
          w_pwm_cnt_d   = '0;
          w_duty_q_d    = i_duty;
        end else begin
          w_cyc_cnt_d = r_cyc_cnt + 1'b1;
        end
      end
      StRun: begin
        if (!w_run) begin
          w_state_d   = StLockout;
          w_cyc_cnt_d = '0;
        end else if (r_presc_cnt == PrescLast) begin
          w_presc_cnt_d = '0;
          w_pwm_cnt_d   = r_pwm_cnt + 1'b1;
          // Reload duty only at a period boundary so a change never cuts a pulse short.
          if (r_pwm_cnt == '1) begin
            w_duty_q_d = i_duty;
          end
        end else begin
          w_presc_cnt_d = r_presc_cnt + 1'b1;
        end
      end
      StLockout: begin
        if (r_cyc_cnt == OffLast) begin
          w_state_d   = StIdle;
          w_cyc_cnt_d = '0;
        end else begin
          w_cyc_cnt_d = r_cyc_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Enable derived from next-state values so it lines up with the state it belongs to.
    case (w_state_d)
      StKick:  w_fan_en_d = 1'b1;
      StRun:   w_fan_en_d = (w_pwm_cnt_d < w_duty_q_d) | (&w_duty_q_d) | i_force;
      default: w_fan_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cyc_cnt   <= '0;
      r_presc_cnt <= '0;
      r_pwm_cnt   <= '0;
      r_duty_q    <= '0;
      r_fan_en    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cyc_cnt   <= w_cyc_cnt_d;
      r_presc_cnt <= w_presc_cnt_d;
      r_pwm_cnt   <= w_pwm_cnt_d;
      r_duty_q    <= w_duty_q_d;
      r_fan_en    <= w_fan_en_d;
    end
  end

  assign o_fan_en = r_fan_en;
  assign o_state  = r_state;
  assign o_busy   = (r_state != StIdle);

endmodule
